// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the N-port APB3 master
package apb_pkg;

  // Master transfer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  // Default peripheral window: 4 KiB per slave starting at 0x1000_0000
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam int          DEF_SPAN_LOG2 = 12;

  // Width of a slave index; a single slave still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational window check and one-hot slave select
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLAVES = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int                SPAN_LOG2  = DEF_SPAN_LOG2
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  o_valid,
  output logic [NUM_SLAVES-1:0] o_sel
);

  logic              w_above;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_region;

  // Region number is the offset from the window base in units of one slave span;
  // comparing the region against NUM_SLAVES avoids overflow of BASE + size
  always_comb begin
    w_above  = (i_addr >= BASE_ADDR);
    w_offset = i_addr - BASE_ADDR;
    w_region = w_offset >> SPAN_LOG2;
    o_valid  = w_above && (w_region < ADDR_W'(NUM_SLAVES));
  end

  // One-hot select, all zero for an address outside the window
  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_sel[i] = o_valid && (w_region == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/apb_master_nport.sv
// rtl/apb_master_nport.sv - APB3 master for NUM_SLAVES slaves; APB_MASTER_TIMEOUT_EN adds wait-state timeout
module apb_master_nport
  import apb_pkg::*;
#(
  parameter int                NUM_SLAVES  = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int                SPAN_LOG2   = DEF_SPAN_LOG2,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         transfer,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         error,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic                         PENABLE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("apb_master_nport: parameter out of range");
  end

  apb_state_e r_state;
  apb_state_e w_state_nxt;

  logic                  w_valid;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      r_idx;

  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_W-1:0]     w_prdata;
  logic                  w_timeout;

  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_penable;
  logic [ADDR_W-1:0]     r_paddr;
  logic                  r_pwrite;
  logic [DATA_W-1:0]     r_pwdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_ready;
  logic                  r_error;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .SPAN_LOG2  (SPAN_LOG2)
  ) u_addr_decoder (
    .i_addr  (addr),
    .o_valid (w_valid),
    .o_sel   (w_sel)
  );

  // Encode the one-hot select so the response mux keys off a small index
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_sel[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  // Response mux: only the slave latched at acceptance is observed
  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_pready  = PREADY[i];
        w_pslverr = PSLVERR[i];
        w_prdata  = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Wait-state counter: cleared while entering ACCESS, counts slave stalls
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !w_pready) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Abandon on the stall cycle that brings the count to TIMEOUT_CYC; a
  // slave that answers in that same cycle still completes normally
  assign w_timeout = (r_state == ACCESS) && !w_pready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (transfer) begin
          w_state_nxt = w_valid ? SETUP : DERR;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (w_pready || w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      DERR: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs: request capture, APB phase control and completion pulse
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_idx     <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (transfer) begin
            r_paddr  <= addr;
            r_pwrite <= write;
            r_pwdata <= wdata;
            r_psel   <= w_sel;
            r_idx    <= w_idx;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_ready   <= 1'b1;
            r_error   <= w_pslverr;
            if (!r_pwrite) begin
              r_rdata <= w_prdata;
            end
          end else if (w_timeout) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_ready   <= 1'b1;
            r_error   <= 1'b1;
          end
        end
        DERR: begin
          r_ready <= 1'b1;
          r_error <= 1'b1;
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PWDATA  = r_pwdata;
  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign error   = r_error;

endmodule

// File: tb/tb_apb_master_nport.sv
// tb/tb_apb_master_nport.sv - scoreboard testbench for apb_master_nport
module tb_apb_master_nport;

  localparam int          NS   = 4;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             transfer;
  logic             write;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic             ready;
  logic             error;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic             PENABLE;
  logic [DW-1:0]    PWDATA;
  logic [NS-1:0]    PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    int          lat;
    int          acc;
    logic [3:0]  psel;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] mem [NS];
  logic        slv_init = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master_nport #(
    .NUM_SLAVES  (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BASE_ADDR   (BASE),
    .SPAN_LOG2   (12),
    .TIMEOUT_CYC (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .error    (error),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Slave register models: one word per slave, written on a completing APB write
  always @(posedge PCLK) begin
    for (int i = 0; i < NS; i++) begin
      if (slv_init) mem[i] <= 32'hA0 + i;
      else if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) mem[i] <= PWDATA;
    end
  end

  always_comb begin
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = mem[i];
  end

  function automatic logic [3:0] exp_sel(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a >= BASE && a < BASE + 32'h4000) return 4'b0001 << off[13:12];
    return 4'b0000;
  endfunction

  // Issue one request at the current negedge and follow it to its ready pulse.
  // Returns at the negedge of the ready cycle so a caller may chain back-to-back.
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic slverr);
    exp_t       e;
    exp_t       g;
    logic [3:0] s;
    int         tgt;
    int         k;
    int         n_setup;
    int         n_acc;
    bit         done;
    bit         stab_ok;
    bit         psel_ok;
    bit         quiet_ok;
    bit         to_hit;
    s   = exp_sel(a);
    tgt = 0;
    for (int i = 0; i < NS; i++) if (s[i]) tgt = i;
    to_hit = 1'b0;
    if (s == 4'b0000) begin
      e.lat = 2; e.acc = 0; e.error = 1'b1;
    end else begin
      e.acc = waits + 1; e.lat = waits + 3; e.error = slverr;
`ifdef APB_MASTER_TIMEOUT_EN
      if (waits >= TO) begin
        e.acc = TO; e.lat = TO + 2; e.error = 1'b1; to_hit = 1'b1;
      end
`endif
      if (!w && !to_hit) model_rdata = mem[tgt];
    end
    e.rdata = model_rdata;
    e.psel  = s;
    sb.push_back(e);

    PSLVERR  = slverr ? s : 4'b0000;
    transfer = 1'b1; write = w; addr = a; wdata = d;
    k = 0; done = 0; n_setup = 0; n_acc = 0; stab_ok = 1; psel_ok = 1; quiet_ok = 1;
    while (!done && k < 100) begin
      @(negedge PCLK);
      k++;
      if (k == 1) begin
        transfer = 1'b0; write = ~w; addr = $urandom; wdata = $urandom;
      end
      PREADY = '1;
      if (s != 0 && k >= 2 && k < 2 + waits) PREADY = ~s;
      if (PSEL != 0 && PSEL != s) psel_ok = 0;
      if (PSEL == 0 && PENABLE) psel_ok = 0;
      if (PSEL != 0 && !PENABLE) n_setup++;
      if (PSEL != 0 && PENABLE) n_acc++;
      if (PSEL != 0 && (PADDR !== a || PWRITE !== w || (w && PWDATA !== d))) stab_ok = 0;
      if (ready === 1'b1) begin
        done = 1;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty: ready with no pending request");
        end else begin
          g = sb.pop_front();
          n_cmp++;
          if (rdata !== g.rdata) begin
            n_bad++; $display("FAIL rdata @%h: got %h expected %h", a, rdata, g.rdata);
          end
          n_cmp++;
          if (error !== g.error) begin
            n_bad++; $display("FAIL error @%h: got %b expected %b", a, error, g.error);
          end
          n_cmp++;
          if (k != g.lat) begin
            n_bad++; $display("FAIL latency @%h: got %0d expected %0d", a, k, g.lat);
          end
          n_cmp++;
          if (n_acc != g.acc || n_setup != ((g.psel != 0) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL phases @%h: got setup=%0d access=%0d expected setup=%0d access=%0d",
                     a, n_setup, n_acc, (g.psel != 0) ? 1 : 0, g.acc);
          end
        end
        n_cmp++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin
          n_bad++; $display("FAIL idle_on_ready @%h: got psel=%b penable=%b expected 0000/0", a, PSEL, PENABLE);
        end
      end else if (error !== 1'b0 || ready !== 1'b0) begin
        quiet_ok = 0;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL no_ready @%h: got no ready within 100 cycles expected ready at %0d", a, e.lat);
    end
    n_cmp++;
    if (!psel_ok) begin
      n_bad++; $display("FAIL psel @%h: got a wrong select pattern expected %b or 0000", a, s);
    end
    n_cmp++;
    if (!stab_ok) begin
      n_bad++; $display("FAIL apb_stable @%h: got PADDR/PWRITE/PWDATA changing expected %h/%b/%h", a, a, w, d);
    end
    n_cmp++;
    if (!quiet_ok) begin
      n_bad++; $display("FAIL stray_pulse @%h: got ready/error outside completion expected 0", a);
    end
    PREADY  = '1;
    PSLVERR = '0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = '1; PSLVERR = '0; slv_init = 1'b1;
    repeat (3) @(negedge PCLK);
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, ready, error} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000000", {PSEL, PENABLE, PWRITE, ready, error});
    end
    n_cmp++;
    if (PADDR !== '0) begin n_bad++; $display("FAIL reset_paddr: got %h expected 0", PADDR); end
    n_cmp++;
    if (PWDATA !== '0) begin n_bad++; $display("FAIL reset_pwdata: got %h expected 0", PWDATA); end
    n_cmp++;
    if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    slv_init = 1'b0;
    PRESET   = 1'b0;
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if (PSEL !== 4'b0000 || ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got psel=%b ready=%b expected 0000/0", PSEL, ready);
    end
  endtask

  task automatic test_writes();
    for (int i = 0; i < NS; i++) begin
      do_xfer(1'b1, BASE + (i << 12), 32'd10 + i, 0, 1'b0);
      @(negedge PCLK);
    end
    for (int i = 0; i < NS; i++) begin
      n_cmp++;
      if (mem[i] !== 32'd10 + i) begin
        n_bad++; $display("FAIL slave%0d_mem: got %0d expected %0d", i, mem[i], 10 + i);
      end
    end
  endtask

  task automatic test_reads();
    do_xfer(1'b0, BASE, 32'h0, 0, 1'b0);
    @(negedge PCLK);
    do_xfer(1'b0, BASE + 32'h2000, 32'h0, 3, 1'b0);
    @(negedge PCLK);
  endtask

  task automatic test_decode_error();
    do_xfer(1'b1, BASE + 32'h4000, 32'h55, 0, 1'b0);
    @(negedge PCLK);
    do_xfer(1'b0, BASE - 32'h4, 32'h0, 0, 1'b0);
    @(negedge PCLK);
    n_cmp++;
    if (mem[0] !== 32'd10 || mem[3] !== 32'd13) begin
      n_bad++; $display("FAIL derr_no_write: got %0d/%0d expected 10/13", mem[0], mem[3]);
    end
  endtask

  task automatic test_slverr();
    do_xfer(1'b0, BASE + 32'h1000, 32'h0, 0, 1'b1);
    @(negedge PCLK);
    do_xfer(1'b0, BASE + 32'h3000, 32'h0, 1, 1'b0);
    @(negedge PCLK);
  endtask

  task automatic test_reset_mid();
    transfer = 1'b1; write = 1'b0; addr = BASE + 32'h2000;
    @(negedge PCLK);
    transfer = 1'b0;
    PREADY   = 4'b1011;
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if (PSEL !== 4'b0100 || PENABLE !== 1'b1) begin
      n_bad++; $display("FAIL mid_access: got psel=%b penable=%b expected 0100/1", PSEL, PENABLE);
    end
    #2 PRESET = 1'b1;
    #1;
    n_cmp++;
    if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got psel=%b penable=%b ready=%b expected 0000/0/0", PSEL, PENABLE, ready);
    end
    n_cmp++;
    if (PADDR !== '0 || rdata !== '0) begin
      n_bad++; $display("FAIL async_reset_regs: got paddr=%h rdata=%h expected 0/0", PADDR, rdata);
    end
    model_rdata = 32'h0;
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = '1;
    @(negedge PCLK);
    do_xfer(1'b0, BASE + 32'h2000, 32'h0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, BASE + 32'h3000, 32'd77, 0, 1'b0);
    do_xfer(1'b0, BASE + 32'h3000, 32'h0, 0, 1'b0);
    do_xfer(1'b1, BASE + 32'h8000, 32'h1, 0, 1'b0);
    do_xfer(1'b0, BASE + 32'h1000, 32'h0, 2, 1'b0);
    @(negedge PCLK);
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, BASE + 32'h3000, 32'h0, 20, 1'b0);
    @(negedge PCLK);
    do_xfer(1'b0, BASE, 32'h0, 5, 1'b0);
    @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_writes();
    test_reads();
    test_decode_error();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
